// File: rtl/pair_triple_threshold_seq.sv
// Registered popcount-threshold detector with a saturating streak counter and alarm pulse.
// Optional sticky "any hit since clear" flag enabled by PAIR_TRIPLE_THRESHOLD_SEQ_STICKY_EN.
module pair_triple_threshold_seq #(
    parameter int unsigned NBITS    = 3,
    parameter int unsigned THRESH   = 2,
    parameter int unsigned SW       = 4,
    parameter int unsigned STREAK_N = 3,
    localparam int unsigned CW      = $clog2(NBITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic [NBITS-1:0] in,
    input  logic             clear,
    output logic             out_val,
    output logic             out,
    output logic [CW-1:0]    count,
    output logic [SW-1:0]    streak,
    output logic             alarm,
    output logic             sticky
);

    localparam logic [SW-1:0] StreakMax    = {SW{1'b1}};
    localparam logic [SW-1:0] StreakTarget = SW'(STREAK_N);

    logic [CW-1:0] pop_c;
    logic          hit_c;

    logic          out_val_q, out_val_d;
    logic          out_q, out_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          alarm_q, alarm_d;

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < int'(NBITS); i++) begin
            pop_c = pop_c + CW'(in[i]);
        end
    end

    // Widened to 32 bits so THRESH > NBITS simply never matches.
    assign hit_c = 32'(pop_c) >= THRESH;

    always_comb begin
        out_val_d = in_val;
        out_d     = out_q;
        count_d   = count_q;
        streak_d  = streak_q;

        if (in_val) begin
            out_d   = hit_c;
            count_d = pop_c;
        end

        if (clear) begin
            streak_d = '0;
        end else if (in_val) begin
            if (!hit_c) begin
                streak_d = '0;
            end else if (streak_q != StreakMax) begin
                streak_d = streak_q + 1'b1;
            end
        end

        // Only fires on the transition into the target, never while held there.
        alarm_d = (streak_d == StreakTarget) && (streak_q != StreakTarget);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val_q <= 1'b0;
            out_q     <= 1'b0;
            count_q   <= '0;
            streak_q  <= '0;
            alarm_q   <= 1'b0;
        end else begin
            out_val_q <= out_val_d;
            out_q     <= out_d;
            count_q   <= count_d;
            streak_q  <= streak_d;
            alarm_q   <= alarm_d;
        end
    end

`ifdef PAIR_TRIPLE_THRESHOLD_SEQ_STICKY_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = clear ? 1'b0 : (sticky_q | (in_val & hit_c));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    assign out_val = out_val_q;
    assign out     = out_q;
    assign count   = count_q;
    assign streak  = streak_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_pair_triple_threshold_seq.sv
// Self-checking bench: behavioural reference model compared every cycle, plus directed
// literal scenarios and a randomized run.
module tb_pair_triple_threshold_seq;

    localparam int NBITS    = 3;
    localparam int THRESH   = 2;
    localparam int SW       = 4;
    localparam int STREAK_N = 3;
    localparam int SMAX     = (1 << SW) - 1;
`ifdef PAIR_TRIPLE_THRESHOLD_SEQ_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_val;
    logic [NBITS-1:0] in_d;
    logic             clear;
    logic             out_val;
    logic             out;
    logic [1:0]       count;
    logic [SW-1:0]    streak;
    logic             alarm;
    logic             sticky;

    pair_triple_threshold_seq #(
        .NBITS   (NBITS),
        .THRESH  (THRESH),
        .SW      (SW),
        .STREAK_N(STREAK_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_val (in_val),
        .in     (in_d),
        .clear  (clear),
        .out_val(out_val),
        .out    (out),
        .count  (count),
        .streak (streak),
        .alarm  (alarm),
        .sticky (sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state (plain integers).
    int m_out_val, m_out, m_count, m_streak, m_alarm, m_sticky;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_out_val = 0; m_out = 0; m_count = 0; m_streak = 0; m_alarm = 0; m_sticky = 0;
    endtask

    task automatic model_edge();
        int pc, ns;
        bit hit;
        if (!reset) begin
            model_zero();
            return;
        end
        pc  = $countones(in_d);
        hit = pc >= THRESH;
        if (clear)       ns = 0;
        else if (in_val) ns = hit ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
        else             ns = m_streak;
        m_alarm = (ns == STREAK_N && m_streak != STREAK_N) ? 1 : 0;
        m_streak = ns;
        m_out_val = in_val ? 1 : 0;
        if (in_val) begin
            m_count = pc;
            m_out   = hit ? 1 : 0;
        end
        if (STICKY_EN) m_sticky = clear ? 0 : ((m_sticky != 0 || (in_val && hit)) ? 1 : 0);
        else           m_sticky = 0;
    endtask

    task automatic step(input logic v, input logic [NBITS-1:0] d, input logic c);
        in_val = v;
        in_d   = d;
        clear  = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out_val", 32'(out_val), 32'(m_out_val));
            chk("cyc_out",     32'(out),     32'(m_out));
            chk("cyc_count",   32'(count),   32'(m_count));
            chk("cyc_streak",  32'(streak),  32'(m_streak));
            chk("cyc_alarm",   32'(alarm),   32'(m_alarm));
            chk("cyc_sticky",  32'(sticky),  32'(m_sticky));
        end
    end

    int cnt_exp [8] = '{0, 1, 1, 2, 1, 2, 2, 3};
    int maj_exp [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
    logic [2:0] hits4 [4] = '{3'b110, 3'b101, 3'b011, 3'b111};
    int streak_seq [5] = '{1, 2, 3, 4, 0};
    int alarm_seq  [5] = '{0, 0, 1, 0, 0};
    int ov_seq [4] = '{1, 0, 0, 1};
    int sk_seq [4] = '{1, 1, 1, 2};

    initial begin
        int n_alarm;
        reset  = 1'b1;
        in_val = 1'b0;
        in_d   = '0;
        clear  = 1'b0;
        model_zero();
        #1 reset = 1'b0;
        #1;
        chk_en = 1'b1;
        chk("rst_out_val", 32'(out_val), 0);
        chk("rst_streak",  32'(streak),  0);
        chk("rst_count",   32'(count),   0);
        @(negedge clk);
        #2 reset = 1'b1;

        // Exhaustive majority table.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 1'b0);
            chk("exh_out",   32'(out),   32'(maj_exp[i]));
            chk("exh_count", 32'(count), 32'(cnt_exp[i]));
        end

        // Streak then miss.
        step(1'b0, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, (i < 4) ? hits4[i] : 3'b001, 1'b0);
            chk("stk_streak", 32'(streak), 32'(streak_seq[i]));
            chk("stk_alarm",  32'(alarm),  32'(alarm_seq[i]));
        end

        // Bubbles hold state.
        step(1'b0, 3'b000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(ov_seq[i] != 0, (i == 0) ? 3'b011 : (i == 3) ? 3'b110 : 3'b000, 1'b0);
            chk("bub_out_val", 32'(out_val), 32'(ov_seq[i]));
            chk("bub_out",     32'(out),     1);
            chk("bub_streak",  32'(streak),  32'(sk_seq[i]));
            chk("bub_alarm",   32'(alarm),   0);
        end

        // Saturation.
        step(1'b0, 3'b000, 1'b1);
        n_alarm = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 3'b111, 1'b0);
            if (alarm) begin
                n_alarm++;
                chk("sat_alarm_at", 32'(streak), 32'(STREAK_N));
            end
        end
        chk("sat_streak",      32'(streak), 15);
        chk("sat_alarm_count", 32'(n_alarm), 1);

        // Clear collides with a valid hit.
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b111, 1'b0);
        step(1'b1, 3'b111, 1'b0);
        chk("clr_pre_streak", 32'(streak), 2);
        step(1'b1, 3'b111, 1'b1);
        chk("clr_out",    32'(out),    1);
        chk("clr_count",  32'(count),  3);
        chk("clr_streak", 32'(streak), 0);
        chk("clr_alarm",  32'(alarm),  0);
        chk("clr_sticky", 32'(sticky), 0);

        // Async reset mid-cycle.
        step(1'b1, 3'b011, 1'b0);
        step(1'b1, 3'b110, 1'b0);
        chk("ar_pre_streak", 32'(streak), 2);
        chk("ar_pre_sticky", 32'(sticky), 32'(STICKY_EN));
        #2;
        reset = 1'b0;
        model_zero();
        #1;
        chk("ar_out_val", 32'(out_val), 0);
        chk("ar_out",     32'(out),     0);
        chk("ar_count",   32'(count),   0);
        chk("ar_streak",  32'(streak),  0);
        chk("ar_sticky",  32'(sticky),  0);
        step(1'b1, 3'b111, 1'b0);
        chk("ar_held_streak", 32'(streak), 0);
        #2 reset = 1'b1;
        step(1'b1, 3'b101, 1'b0);
        chk("ar_post_streak", 32'(streak), 1);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(3) != 0, 3'($urandom), $urandom_range(15) == 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
